// File: rtl/wb_port_splitter.sv
// Registered 1-to-NUM_PORTS Wishbone classic splitter with bus timeout,
// unmapped-port error response and master-abort handling.
module wb_port_splitter #(
  parameter int unsigned NUM_PORTS = 8,
  parameter int unsigned ADR_WIDTH = 12,
  parameter int unsigned DAT_WIDTH = 32,
  parameter int unsigned SEL_LSB   = 6,
  parameter int unsigned SEL_BITS  = 3,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_n_i,
  input  logic                               wb_cyc_i,
  input  logic                               wb_stb_i,
  input  logic                               wb_we_i,
  input  logic [ADR_WIDTH-1:0]               wb_adr_i,
  input  logic [DAT_WIDTH-1:0]               wb_dat_i,
  input  logic [DAT_WIDTH/8-1:0]             wb_sel_i,
  output logic                               wb_ack_o,
  output logic                               wb_err_o,
  output logic                               wb_rty_o,
  output logic [DAT_WIDTH-1:0]               wb_dat_o,
  output logic [NUM_PORTS-1:0]               wbvec_cyc_o,
  output logic [NUM_PORTS-1:0]               wbvec_stb_o,
  output logic [NUM_PORTS-1:0]               wbvec_we_o,
  output logic [NUM_PORTS*ADR_WIDTH-1:0]     wbvec_adr_o,
  output logic [NUM_PORTS*DAT_WIDTH-1:0]     wbvec_dat_o,
  output logic [NUM_PORTS*(DAT_WIDTH/8)-1:0] wbvec_sel_o,
  input  logic [NUM_PORTS-1:0]               wbvec_ack_i,
  input  logic [NUM_PORTS-1:0]               wbvec_err_i,
  input  logic [NUM_PORTS*DAT_WIDTH-1:0]     wbvec_dat_i,
  output logic [7:0]                         timeout_count_o,
  output logic [SEL_BITS-1:0]                last_err_port_o
);

  localparam int unsigned SW = DAT_WIDTH / 8;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]           state;
  logic [SEL_BITS-1:0]  idx;
  logic [ADR_WIDTH-1:0] adr_q;
  logic [DAT_WIDTH-1:0] dat_q;
  logic [SW-1:0]        sel_q;
  logic                 we_q;
  logic [15:0]          tmo_cnt;

  logic [SEL_BITS-1:0]  req_idx;
  logic                 req_mapped;
  logic                 sel_ack;
  logic                 sel_err;
  logic [DAT_WIDTH-1:0] sel_dat;

  assign req_idx    = wb_adr_i[SEL_LSB +: SEL_BITS];
  assign req_mapped = 32'(req_idx) < NUM_PORTS;

  assign wb_rty_o    = 1'b0;
  assign wbvec_adr_o = {NUM_PORTS{adr_q}};
  assign wbvec_dat_o = {NUM_PORTS{dat_q}};
  assign wbvec_sel_o = {NUM_PORTS{sel_q}};
  assign wbvec_we_o  = {NUM_PORTS{we_q}};

  // Only the latched port is observed; responses from other ports never leak through.
  always_comb begin
    sel_ack     = 1'b0;
    sel_err     = 1'b0;
    sel_dat     = '0;
    wbvec_cyc_o = '0;
    wbvec_stb_o = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (SEL_BITS'(i) == idx) begin
        sel_ack = wbvec_ack_i[i];
        sel_err = wbvec_err_i[i];
        sel_dat = wbvec_dat_i[i*DAT_WIDTH +: DAT_WIDTH];
        if (state == ACTIVE) begin
          wbvec_cyc_o[i] = 1'b1;
          wbvec_stb_o[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state           <= IDLE;
      idx             <= '0;
      adr_q           <= '0;
      dat_q           <= '0;
      sel_q           <= '0;
      we_q            <= 1'b0;
      tmo_cnt         <= '0;
      wb_ack_o        <= 1'b0;
      wb_err_o        <= 1'b0;
      wb_dat_o        <= '0;
      timeout_count_o <= '0;
      last_err_port_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            idx   <= req_idx;
            adr_q <= wb_adr_i;
            dat_q <= wb_dat_i;
            sel_q <= wb_sel_i;
            we_q  <= wb_we_i;
            if (!req_mapped) begin
              state           <= RESP;
              wb_err_o        <= 1'b1;
              wb_dat_o        <= '0;
              last_err_port_o <= req_idx;
              if (timeout_count_o != 8'hFF) timeout_count_o <= timeout_count_o + 8'd1;
            end else begin
              state   <= ACTIVE;
              tmo_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          // Abort takes priority: with the master gone, any response is meaningless.
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (sel_ack) begin
            state    <= RESP;
            wb_ack_o <= 1'b1;
            wb_dat_o <= sel_dat;
          end else if (sel_err) begin
            state    <= RESP;
            wb_err_o <= 1'b1;
            wb_dat_o <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state           <= RESP;
            wb_err_o        <= 1'b1;
            wb_dat_o        <= '0;
            last_err_port_o <= idx;
            if (timeout_count_o != 8'hFF) timeout_count_o <= timeout_count_o + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
